lfsr_prbs_checker: RTL and testbench
====================================

Name: lfsr_prbs_checker

Overview:
- Receive-side companion to the team's Fibonacci LFSR sequence generator: checks a serial bitstream against the same LFSR polynomial.
- Self-synchronising: seeds its own shift register from the incoming stream, declares lock after a run of correct predictions, then counts bit errors.
- Sits at the sink of a generator-to-checker link as a BIST/link-integrity monitor.

Parameters:
- WIDTH, 3, LFSR length in bits (>=2).
- TAPS, 3'b110, feedback mask; predicted bit = XOR of (shift & TAPS). Default is x^3+x^2+1, period 7.
- LOCK_CNT, 8, consecutive correct predictions needed to enter LOCKED (1..255).
- LOSS_CNT, 3, consecutive mispredictions in LOCKED that force return to SEARCH (1..255).
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  received serial bit; sampled only when din_vld=1.
- din_vld  in  1  qualifies din for one bit per cycle.
- clr_cnt  in  1  synchronous clear of err_cnt (no effect on lock state).
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mispredicted bit while LOCKED.
- err_cnt  out  ERR_W  saturating count of mispredicted bits while LOCKED.

Behaviour:
- Reset (rst_n=0, async): FSM=SEARCH; shift, fill counter, match counter and miss counter = 0; locked=0, err_pulse=0, err_cnt=0.
- Cycles with din_vld=0: no state change. err_pulse is 0 in any such cycle.
- Shift update (every valid bit, all states): shift <= {shift[WIDTH-2:0], din}. The received bit is always shifted in, never the predicted bit.
- Prediction: p = ^(shift & TAPS), evaluated on shift before the update. mismatch = (din != p).
- SEARCH:
  - The first WIDTH valid bits after reset or after loss of lock only fill the shift register (fill counter 0..WIDTH). No comparison is made.
  - After that, each valid bit does the following: match -> match counter +1; mismatch -> match counter = 0.
  - When the match counter reaches LOCK_CNT on a valid bit, go to LOCKED, with locked=1 from the next cycle.
  - If shift is all-zero, that bit does not count as a match: the match counter is held at 0. This prevents false lock on an idle all-zero line.
  - No errors are counted in SEARCH.
- LOCKED:
  - mismatch -> err_pulse=1 in the next cycle, err_cnt+1 (saturating at all-ones, no wrap), miss counter +1.
  - match -> miss counter = 0.
  - The miss counter reaching LOSS_CNT, or the post-update shift becoming all-zero, causes a transition to SEARCH:
    - locked=0 next cycle;
    - fill counter = 0 and match counter = 0;
    - the bit that caused loss is still counted as an error if it mispredicted.
- Latency: locked, err_pulse and err_cnt are all registered and update exactly 1 cycle after the sampling edge of the causing din.
- clr_cnt:
  - clr_cnt=1 sets err_cnt to 0 on the next edge.
  - If a counted error occurs in the same cycle, clear wins: err_cnt=0, but err_pulse is still asserted.
- Reset mid-stream: immediate return to reset values; lock must be reacquired (WIDTH + LOCK_CNT valid bits minimum).
- Single-bit error in LOCKED (self-sync form): the bad bit corrupts the next predictions wherever it sits in a tap position.
  - With the default TAPS, one flipped bit yields exactly 3 err_pulses: the flipped bit itself, plus 2 later ones when it reaches taps 1 and 2.
  - LOSS_CNT=3 does not trigger on this, because the misses are not consecutive.

Test Plan:
- Acquire: reset, then drive the default period-7 sequence 0,1,1,1,0,0,1 repeated continuously with din_vld=1 → locked=1 exactly 1 cycle after valid bit 11 (3 fill + 8 matches); err_cnt=0 after 100 bits.
- Gapped valid: same stream with din_vld toggling 1,0,1,0 → lock occurs on the same valid-bit count (bit 11); no err_pulse during gaps.
- Single error: once locked, invert one bit → exactly 3 err_pulses, err_cnt=3, locked stays 1; a subsequent clr_cnt pulse → err_cnt=0.
- Loss of lock:
  - once locked, drive all-zero bits → locked=0 once shift becomes all-zero, with err_cnt incremented for each mispredicted bit up to that point;
  - all-zero input held for 50 bits → never relocks;
  - resuming the valid sequence → relocks after 11 valid bits.
- Saturation: ERR_W=4, lock, then inject periodic single errors → err_cnt stops at 15 and does not wrap.
- Async reset mid-lock: assert rst_n=0 between clock edges → locked, err_pulse and err_cnt go to 0 immediately; after release, lock is reacquired after 11 valid bits.

Source files
------------

// File: rtl/lfsr_prbs_checker.sv
// rtl/lfsr_prbs_checker.sv - self-synchronising Fibonacci LFSR PRBS checker
//
// Purpose:
//   Receive-side checker for a serial PRBS produced by a Fibonacci LFSR with
//   the same WIDTH/TAPS. The shift register is seeded from the received
//   stream. Lock is declared after LOCK_CNT consecutive correct predictions.
//   Once locked, every mispredicted bit is counted as an error.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   received serial bit, sampled when din_vld=1
//   din_vld    in   qualifies din (one bit per cycle)
//   clr_cnt    in   synchronous clear of err_cnt (lock state untouched)
//   locked     out  high while in LOCKED
//   err_pulse  out  one-cycle pulse per mispredicted bit while LOCKED
//   err_cnt    out  saturating count of mispredicted bits while LOCKED

module lfsr_prbs_checker #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS     = 3'b110,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 3,
  parameter int               ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FILL_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [FILL_W-1:0] r_fill;
  logic [7:0]        r_match;
  logic [7:0]        r_miss;
  logic              r_locked;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_pred;
  logic              w_mismatch;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic              w_filled;
  logic              w_shift_zero;
  logic              w_nxt_zero;
  logic [7:0]        w_match_inc;
  logic [7:0]        w_miss_inc;
  logic              w_lose;

  // Prediction is taken from the register contents before this bit is shifted in.
  assign w_pred       = ^(r_shift & TAPS);
  assign w_mismatch   = din ^ w_pred;
  assign w_shift_nxt  = {r_shift[WIDTH-2:0], din};
  assign w_filled     = (r_fill == FILL_W'(WIDTH));
  assign w_shift_zero = (r_shift == '0);
  assign w_nxt_zero   = (w_shift_nxt == '0);
  assign w_match_inc  = r_match + 8'd1;
  assign w_miss_inc   = r_miss + 8'd1;
  // Loss on LOSS_CNT consecutive misses, or when the register collapses to
  // all-zero (the LFSR lock-up state, which can never predict a 1).
  assign w_lose       = (w_mismatch && (w_miss_inc == 8'(LOSS_CNT))) || w_nxt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_shift     <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;

      if (din_vld) begin
        // The received bit is always shifted in, so the checker re-seeds itself.
        r_shift <= w_shift_nxt;

        if (r_state == ST_SEARCH) begin
          if (!w_filled) begin
            r_fill <= r_fill + FILL_W'(1);
          end else if (w_mismatch || w_shift_zero) begin
            // An all-zero register trivially predicts an idle line; never count it.
            r_match <= '0;
          end else if (w_match_inc == 8'(LOCK_CNT)) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
            r_match  <= '0;
            r_miss   <= '0;
          end else begin
            r_match <= w_match_inc;
          end
        end else begin
          if (w_mismatch) begin
            r_err_pulse <= 1'b1;
            if (!(&r_err_cnt)) begin
              r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            r_miss <= w_miss_inc;
          end else begin
            r_miss <= '0;
          end

          if (w_lose) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_fill   <= '0;
            r_match  <= '0;
            r_miss   <= '0;
          end
        end
      end

      // Placed last so a clear overrides a same-cycle increment.
      if (clr_cnt) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb/tb_lfsr_prbs_checker.sv - directed scoreboard bench for lfsr_prbs_checker

module tb_lfsr_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_vld;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic        s_locked;
  logic        s_pulse;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  lfsr_prbs_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  lfsr_prbs_checker #(.ERR_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .clr_cnt   (clr_cnt),
    .locked    (s_locked),
    .err_pulse (s_pulse),
    .err_cnt   (s_cnt)
  );

  typedef struct {
    logic lk;
    logic pl;
    int   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;
  bit   seq[7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int   phase    = 0;
  logic exp_lock = 1'b0;
  int   exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input logic lk, input logic pl, input int cnt);
    check({tag, ".locked"},     32'(locked),    32'(lk));
    check({tag, ".err_pulse"},  32'(err_pulse), 32'(pl));
    check({tag, ".err_cnt"},    32'(err_cnt),   cnt);
    check({tag, ".sat_locked"}, 32'(s_locked),  32'(lk));
    check({tag, ".sat_pulse"},  32'(s_pulse),   32'(pl));
    check({tag, ".sat_cnt"},    32'(s_cnt),     (cnt > 15) ? 15 : cnt);
  endtask

  // Drive one cycle of input; the expectation for the following edge is queued
  // and popped once the outputs have settled after that edge.
  task automatic step(input logic b, input logic v, input logic c,
                      input logic lk, input logic pl, input int cnt);
    exp_t e;
    din     = b;
    din_vld = v;
    clr_cnt = c;
    e.lk    = lk;
    e.pl    = pl;
    e.cnt   = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_step++;
    e = sb_q.pop_front();
    check_outs($sformatf("step%0d", n_step), e.lk, e.pl, e.cnt);
    clr_cnt = 1'b0;
  endtask

  task automatic run_seq(input int n, input int lock_on);
    for (int i = 1; i <= n; i++) begin
      if (i == lock_on) exp_lock = 1'b1;
      step(seq[phase], 1'b1, 1'b0, exp_lock, 1'b0, exp_cnt);
      phase = (phase + 1) % 7;
    end
  endtask

  task automatic run_seq_gapped(input int n, input int lock_on);
    for (int i = 1; i <= n; i++) begin
      if (i == lock_on) exp_lock = 1'b1;
      step(seq[phase], 1'b1, 1'b0, exp_lock, 1'b0, exp_cnt);
      phase = (phase + 1) % 7;
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, exp_lock, 1'b0, exp_cnt);
    end
  endtask

  // Invert the phase-0 bit (a 0, so no window becomes all-zero). Errors are
  // expected on the flipped bit and two and three bits later.
  task automatic flip(input bit clr_k, input bit early);
    run_seq((7 - phase) % 7, 0);
    exp_cnt = clr_k ? 0 : exp_cnt + 1;
    step(!seq[0], 1'b1, clr_k, 1'b1, 1'b1, exp_cnt);
    phase = 1;
    if (!early) begin
      step(seq[1], 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
      exp_cnt++;
      step(seq[2], 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt);
      exp_cnt++;
      step(seq[3], 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt);
      step(seq[4], 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
      phase = 5;
    end
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    din_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs(tag, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_lock = 1'b0;
    exp_cnt  = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = 1'b0;
    din_vld = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire: lock after bit 11, no errors over 100 bits.
    run_seq(100, 11);

    // Gapped valid: same lock point in valid-bit terms, quiet during gaps.
    async_reset("reset_gap");
    phase = 0;
    run_seq_gapped(16, 11);

    // Single error gives three pulses; then clear.
    flip(1'b0, 1'b0);
    exp_cnt = 0;
    step(seq[phase], 1'b1, 1'b1, 1'b1, 1'b0, exp_cnt);
    phase = (phase + 1) % 7;

    // Clear coincident with a counted error: clear wins, pulse still seen.
    flip(1'b1, 1'b0);
    exp_cnt = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);

    // Loss of lock on an all-zero line, no relock while idle, then relock.
    run_seq((7 - phase) % 7, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
    exp_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt);
    exp_cnt++;
    exp_lock = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_cnt);
    for (int i = 0; i < 47; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
    end
    phase = 0;
    run_seq(11, 11);
    run_seq(10, 0);

    // Async reset while locked with a pulse in flight, then reacquire.
    async_reset("reset_pre");
    phase = 0;
    run_seq(11, 11);
    flip(1'b0, 1'b1);
    async_reset("reset_midlock");
    phase = 3;
    run_seq(11, 11);

    // Saturation: 6 single errors = 18; the 4-bit instance holds at 15.
    async_reset("reset_sat");
    phase = 0;
    run_seq(11, 11);
    repeat (6) flip(1'b0, 1'b0);
    run_seq(7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
